// File: rtl/rr_arbiter_2to1_if.sv
// rr_arbiter_2to1_if: handshake and data bundle between the two producers,
// the round-robin arbiter and the downstream consumer / 2:1 mux.
// The master modport is the environment side (producers plus consumer).
// The slave modport is the arbiter side.
interface rr_arbiter_2to1_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;
  logic             busy;

  modport master (
    output req_valid, req_data0, req_data1, out_ready,
    input  req_ready, out_valid, out_data, sel, busy
  );

  modport slave (
    input  req_valid, req_data0, req_data1, out_ready,
    output req_ready, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/rr_arbiter_2to1.sv
// rr_arbiter_2to1: two-requester round-robin arbiter with a one-entry
// registered output buffer and a registered mux select (sel).
// Optional feature macro: RR_ARBITER_2TO1_STATS_EN adds saturating 16-bit
// per-requester accept counters on grant_cnt0 / grant_cnt1.
module rr_arbiter_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_arbiter_2to1_if.slave     bus
`ifdef RR_ARBITER_2TO1_STATS_EN
  ,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] data_reg;
  logic             sel_reg;
  logic             last_reg;

  logic             can_accept;
  logic             any_valid;
  logic             grant_idx;
  logic             accept;
  logic [WIDTH-1:0] grant_data;

  // Grant selection: tie goes to the requester that did not win last time.
  always_comb begin
    can_accept = (state_reg == ST_EMPTY) || bus.out_ready;
    any_valid  = |bus.req_valid;
    if (&bus.req_valid) begin
      grant_idx = ~last_reg;
    end else begin
      grant_idx = bus.req_valid[1];
    end
    // rst_n gates the accept so nothing is handshaken during a reset cycle.
    accept     = any_valid && can_accept && rst_n;
    grant_data = grant_idx ? bus.req_data1 : bus.req_data0;
    bus.req_ready = 2'b00;
    bus.req_ready[grant_idx] = accept;
  end

  // Buffer, select and priority pointer; drain without accept only empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      data_reg  <= '0;
      sel_reg   <= 1'b0;
      last_reg  <= 1'b1;
    end else if (accept) begin
      state_reg <= ST_FULL;
      data_reg  <= grant_data;
      sel_reg   <= grant_idx;
      last_reg  <= grant_idx;
    end else if ((state_reg == ST_FULL) && bus.out_ready) begin
      state_reg <= ST_EMPTY;
    end
  end

  assign bus.out_valid = (state_reg == ST_FULL);
  assign bus.busy      = (state_reg == ST_FULL);
  assign bus.out_data  = data_reg;
  assign bus.sel       = sel_reg;

`ifdef RR_ARBITER_2TO1_STATS_EN
  logic [15:0] cnt_reg [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      // Count accepts for requester gi, sticking at all-ones.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (accept && (grant_idx == gi[0]) && (cnt_reg[gi] != 16'hFFFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign grant_cnt0 = cnt_reg[0];
  assign grant_cnt1 = cnt_reg[1];
`endif

endmodule

// File: tb/tb_rr_arbiter_2to1.sv
// tb_rr_arbiter_2to1: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the arbiter.
module tb_rr_arbiter_2to1;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter_2to1_if #(.WIDTH(WIDTH)) bus ();

`ifdef RR_ARBITER_2TO1_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
`endif

  rr_arbiter_2to1 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef RR_ARBITER_2TO1_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model state: what the buffer holds and who won most recently.
  bit         m_known = 0;
  bit         m_full;
  logic [7:0] m_data;
  int         m_sel;
  int         m_last_winner;
  int         m_cnt [2];
  int         transfers = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner by the fairness rule: contested -> the one that did not win last.
  function automatic int winner(input logic [1:0] v);
    if (v == 2'b11) return 1 - m_last_winner;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  // One clock cycle: drive, check everything, then advance the model.
  task automatic step(input logic r, input logic [1:0] v, input logic [7:0] d0,
                      input logic [7:0] d1, input logic ordy);
    int w;
    bit acc;
    logic [1:0] exp_ready;
    @(negedge clk);
    rst_n         = r;
    bus.req_valid = v;
    bus.req_data0 = d0;
    bus.req_data1 = d1;
    bus.out_ready = ordy;
    #1;
    w   = winner(v);
    acc = r && m_known && (w >= 0) && (!m_full || ordy);
    exp_ready = 2'b00;
    if (acc) exp_ready[w] = 1'b1;
    if (!r) exp_ready = 2'b00;
    if (r || m_known) chk("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_ready});
    if (m_known) begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
      chk("busy",      {31'd0, bus.busy},      {31'd0, m_full});
      chk("out_data",  {24'd0, bus.out_data},  {24'd0, m_data});
      chk("sel",       {31'd0, bus.sel},       m_sel);
`ifdef RR_ARBITER_2TO1_STATS_EN
      chk("grant_cnt0", {16'd0, grant_cnt0}, m_cnt[0]);
      chk("grant_cnt1", {16'd0, grant_cnt1}, m_cnt[1]);
`endif
    end
    @(posedge clk);
    if (!r) begin
      m_known = 1; m_full = 0; m_data = 8'h00; m_sel = 0; m_last_winner = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_known) begin
      if (m_full && ordy) transfers++;
      if (acc) begin
        m_full = 1; m_data = (w == 1) ? d1 : d0; m_sel = w; m_last_winner = w;
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end else if (m_full && ordy) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  logic [7:0] exp_seq [4];
  int         sel_seq [4];

  initial begin
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.out_ready = 1'b0;

    // Reset for two cycles with both requesting.
    step(0, 2'b11, 8'h11, 8'h22, 1);
    step(0, 2'b11, 8'h11, 8'h22, 1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_sel",       {31'd0, bus.sel}, 0);
    chk("rst_out_data",  {24'd0, bus.out_data}, 0);
    chk("rst_ready",     {30'd0, bus.req_ready}, 0);
    $display("reset: out_valid=%0d sel=%0d out_data=%02h", bus.out_valid, bus.sel, bus.out_data);

    // Contention at full throughput: strict alternation starting with 0.
    exp_seq[0] = 8'hA0; exp_seq[1] = 8'hB1; exp_seq[2] = 8'hA0; exp_seq[3] = 8'hB1;
    sel_seq[0] = 0; sel_seq[1] = 1; sel_seq[2] = 0; sel_seq[3] = 1;
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b11, 8'hA0, 8'hB1, 1);
      chk("cont_data", {24'd0, bus.out_data}, {24'd0, exp_seq[i]});
      chk("cont_sel",  {31'd0, bus.sel}, sel_seq[i]);
      $display("contention %0d: out_data=%02h sel=%0d", i, bus.out_data, bus.sel);
    end

    // Backpressure: buffer holds B1, nothing accepted.
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b11, 8'hC0, 8'hD1, 0);
      chk("bp_data",  {24'd0, bus.out_data}, 32'hB1);
      chk("bp_sel",   {31'd0, bus.sel}, 1);
      chk("bp_valid", {31'd0, bus.out_valid}, 1);
      $display("backpressure %0d: out_data=%02h sel=%0d", i, bus.out_data, bus.sel);
    end
    step(1, 2'b11, 8'hC0, 8'hD1, 1);
    chk("bp_release_data",  {24'd0, bus.out_data}, 32'hC0);
    chk("bp_release_valid", {31'd0, bus.out_valid}, 1);
    $display("backpressure release: out_data=%02h valid=%0d", bus.out_data, bus.out_valid);

    // Single requester 1: consecutive grants, no forced alternation.
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b10, 8'h00, 8'hE1 + 8'(i), 1);
      chk("single_sel",  {31'd0, bus.sel}, 1);
      chk("single_data", {24'd0, bus.out_data}, 32'hE1 + i);
      $display("single %0d: out_data=%02h sel=%0d", i, bus.out_data, bus.sel);
    end

    // Mid-operation reset while holding 5A.
    step(1, 2'b01, 8'h5A, 8'h00, 1);
    chk("mid_full_data", {24'd0, bus.out_data}, 32'h5A);
    begin
      int t0;
      t0 = transfers;
      step(0, 2'b00, 8'h00, 8'h00, 0);
      chk("mid_rst_valid", {31'd0, bus.out_valid}, 0);
      chk("mid_rst_no_xfer", transfers, t0);
      $display("mid reset: out_valid=%0d", bus.out_valid);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0), 2'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    $display("random: %0d cycles, %0d transfers", 3000, transfers);

`ifdef RR_ARBITER_2TO1_STATS_EN
    step(0, 2'b00, 8'h00, 8'h00, 1);
    for (int i = 0; i < 70000; i++) step(1, 2'b01, 8'(i), 8'h00, 1);
    chk("stats_cnt0_sat", {16'd0, grant_cnt0}, 32'hFFFF);
    chk("stats_cnt1_zero", {16'd0, grant_cnt1}, 0);
    $display("stats: grant_cnt0=%04h grant_cnt1=%04h", grant_cnt0, grant_cnt1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
